// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, reads the combinational ROM and buffers
// fetched words in a circular prefetch queue that decode drains via valid/ready.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_instruction,
  output logic        out_valid,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        freeze,
  output logic [31:0] fetch_count
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [31:0]      pc;
  logic [31:0]      queue_pc    [DEPTH];
  logic [31:0]      queue_instr [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  // Occupancy before the edge gates the push, so a full queue pops once before refilling.
  assign push = !redirect_valid && !freeze && (count < FULL_COUNT);
  assign pop  = out_valid && out_ready && !redirect_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc          <= pc + 32'd4;
        wr_ptr      <= wr_ptr + PTR_ONE;
        fetch_count <= fetch_count + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (push) begin
      queue_pc[wr_ptr]    <= pc;
      queue_instr[wr_ptr] <= rom_instruction;
    end
  end

  assign rom_address     = pc;
  assign out_valid       = (count != '0);
  assign out_instruction = out_valid ? queue_instr[rd_ptr] : 32'h0;
  assign out_pc          = out_valid ? queue_pc[rd_ptr]    : 32'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a combinational ROM model feeds the DUT and
// each step checks outputs against hand-computed values with immediate assertions.
module tb_instr_fetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] rom_address;
  logic [31:0] rom_instruction;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        freeze;
  logic [31:0] fetch_count;

  int n_assert;
  int n_fail;

  instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_ready       (out_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .freeze          (freeze),
    .fetch_count     (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   rom_word = 32'h8001060A;
      32'h4:   rom_word = 32'h04011000;
      32'h8:   rom_word = 32'h0C011800;
      default: rom_word = a ^ 32'hDEADBEEF;
    endcase
  endfunction

  always_comb rom_instruction = reset ? 32'h0 : rom_word(rom_address);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic head(input string tag, input logic [31:0] pc_exp);
    check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    check({tag, "_pc"}, out_pc, pc_exp);
    check({tag, "_instr"}, out_instruction, rom_word(pc_exp));
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    freeze         = 1'b0;

    // Reset state
    step(2);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_instr", out_instruction, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_fcount", fetch_count, 32'h0);
    check("rst_romaddr", rom_address, 32'h0);

    // Streaming with out_ready high
    reset = 1'b0;
    step(1);
    head("s0", 32'h0);
    check("s0_instr_lit", out_instruction, 32'h8001060A);
    check("s0_romaddr", rom_address, 32'h4);
    step(1);
    head("s1", 32'h4);
    check("s1_instr_lit", out_instruction, 32'h04011000);
    step(1);
    head("s2", 32'h8);
    check("s2_instr_lit", out_instruction, 32'h0C011800);
    check("s2_fcount", fetch_count, 32'd3);

    // Fill with out_ready low
    reset = 1'b1;
    step(1);
    reset     = 1'b0;
    out_ready = 1'b0;
    step(6);
    head("full_head", 32'h0);
    check("full_romaddr", rom_address, 32'h10);
    check("full_fcount", fetch_count, 32'd4);
    out_ready = 1'b1;
    step(1);
    head("drain1", 32'h4);
    check("drain1_romaddr", rom_address, 32'h10);
    check("drain1_fcount", fetch_count, 32'd4);
    step(1);
    head("drain2", 32'h8);
    check("drain2_fcount", fetch_count, 32'd5);
    step(1);
    head("drain3", 32'hC);
    step(1);
    head("drain4", 32'h10);

    // Redirect from a full queue
    reset = 1'b1;
    step(1);
    reset     = 1'b0;
    out_ready = 1'b0;
    step(5);
    check("rd_pre_romaddr", rom_address, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8B;
    step(1);
    redirect_valid = 1'b0;
    check("rd_valid", {31'h0, out_valid}, 32'h0);
    check("rd_pc_zero", out_pc, 32'h0);
    check("rd_romaddr", rom_address, 32'h88);
    check("rd_fcount", fetch_count, 32'd4);
    out_ready = 1'b1;
    step(1);
    head("rd_target", 32'h88);
    check("rd_fcount2", fetch_count, 32'd5);

    // Freeze while draining
    out_ready = 1'b0;
    step(3);
    check("fz_fill_fcount", fetch_count, 32'd8);
    freeze    = 1'b1;
    out_ready = 1'b1;
    step(1);
    head("fz_pop1", 32'h8C);
    step(3);
    check("fz_empty", {31'h0, out_valid}, 32'h0);
    check("fz_romaddr", rom_address, 32'h98);
    check("fz_fcount", fetch_count, 32'd8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step(1);
    redirect_valid = 1'b0;
    check("fz_rd_romaddr", rom_address, 32'h40);
    step(1);
    check("fz_hold_valid", {31'h0, out_valid}, 32'h0);
    check("fz_hold_romaddr", rom_address, 32'h40);
    check("fz_hold_fcount", fetch_count, 32'd8);
    freeze = 1'b0;
    step(1);
    head("fz_release", 32'h40);
    check("fz_release_fcount", fetch_count, 32'd9);

    // PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFFFFFC;
    step(1);
    redirect_valid = 1'b0;
    check("wrap_romaddr", rom_address, 32'hFFFFFFFC);
    step(1);
    head("wrap0", 32'hFFFFFFFC);
    step(1);
    head("wrap1", 32'h0);
    step(1);
    head("wrap2", 32'h4);
    check("wrap_fcount", fetch_count, 32'd12);

    // Reset with three entries queued
    out_ready = 1'b0;
    step(2);
    check("mid_romaddr", rom_address, 32'h10);
    reset = 1'b1;
    step(1);
    check("mid_valid", {31'h0, out_valid}, 32'h0);
    check("mid_fcount", fetch_count, 32'h0);
    check("mid_romaddr_rst", rom_address, 32'h0);
    reset     = 1'b0;
    out_ready = 1'b1;
    step(1);
    head("mid_restart", 32'h0);
    check("mid_restart_fcount", fetch_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
